hmc_phy_lane_model: RTL and testbench

//  Parametrised transceiver (PHY) emulation between the HMC controller PHY port and the link BFM.

---
 rtl/hmc_phy_pkg.sv | 20 ++
 rtl/hmc_phy_lane_aligner.sv | 81 ++++++++
 rtl/hmc_phy_lane_model.sv | 138 +++++++++++++
 tb/tb_hmc_phy_lane_model.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hmc_phy_pkg.sv
// Shared types and lane-mapping helpers for the HMC PHY lane emulation model.
// Lane l bit b lives at data index b*NUM_LANES+l in both directions.
package hmc_phy_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    TX_WAIT = 2'd1,
    RX_WAIT = 2'd2,
    READY   = 2'd3
  } phy_state_t;

  function automatic int lane_bit_idx(input int lane, input int bit_i, input int num_lanes);
    return bit_i * num_lanes + lane;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hmc_phy_lane_aligner.sv
// One RX lane: two-word window, injectable misalignment offset with bit-slip correction,
// and polarity inversion (injected impairment XOR controller correction).
module hmc_phy_lane_aligner
  import hmc_phy_pkg::*;
#(
  parameter int LANE_W = 32,
  parameter int OFF_W  = $clog2(LANE_W)
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              rx_ready,
  input  logic              slip,
  input  logic              offset_load,
  input  logic [OFF_W-1:0]  offset_cfg,
  input  logic              invert,
  input  logic              polarity,
  input  logic [LANE_W-1:0] lane_in,
  output logic [LANE_W-1:0] lane_out,
  output logic              aligned
);

  localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(LANE_W - 1);
  localparam logic [OFF_W:0]   LANE_W_C = (OFF_W + 1)'(LANE_W);

  logic [LANE_W-1:0]   cur_r;
  logic [LANE_W-1:0]   prev_r;
  logic [LANE_W-1:0]   out_r;
  logic [OFF_W-1:0]    off_r;
  logic                aligned_r;
  logic [OFF_W-1:0]    off_nxt_s;
  logic [2*LANE_W-1:0] win_s;
  logic [OFF_W:0]      base_s;
  logic [LANE_W-1:0]   w_s;

  // Next offset: a config load beats a same-cycle slip; slips only count once RX is ready.
  always_comb begin
    off_nxt_s = off_r;
    if (offset_load) begin
      off_nxt_s = offset_cfg;
    end else if (slip && rx_ready) begin
      off_nxt_s = (off_r == OFF_MAX) ? '0 : off_r + 1'b1;
    end else begin
      off_nxt_s = off_r;
    end
  end

  // Window select: offset 0 yields the current word, larger offsets pull in older bits.
  always_comb begin
    win_s  = {cur_r, prev_r};
    base_s = LANE_W_C - {1'b0, off_r};
    w_s    = win_s[base_s +: LANE_W];
  end

  // Offset register and its registered aligned flag.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      off_r     <= '0;
      aligned_r <= 1'b1;
    end else begin
      off_r     <= off_nxt_s;
      aligned_r <= (off_nxt_s == '0);
    end
  end

  // Two-stage RX pipeline: capture window, then shift and apply polarity.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cur_r  <= '0;
      prev_r <= '0;
      out_r  <= '0;
    end else begin
      cur_r  <= lane_in;
      prev_r <= cur_r;
      out_r  <= w_s ^ {LANE_W{invert ^ polarity}};
    end
  end

  assign lane_out = out_r;
  assign aligned  = aligned_r;

endmodule

// File: rtl/hmc_phy_lane_model.sv
// Transceiver emulation between the HMC controller PHY port and the link BFM: ready
// sequencing, registered TX pass-through, and per-lane RX impairments the controller must train out.
module hmc_phy_lane_model
  import hmc_phy_pkg::*;
#(
  parameter int DWIDTH       = 512,
  parameter int NUM_LANES    = 16,
  parameter int TX_READY_DLY = 16,
  parameter int RX_READY_DLY = 32,
  parameter int OFF_W        = $clog2(DWIDTH / NUM_LANES)
) (
  input  logic                       clk_hmc,
  input  logic                       res_n_hmc,
  input  logic                       phy_init_cont_set,
  input  logic [DWIDTH-1:0]          phy_data_tx_link2phy,
  output logic [DWIDTH-1:0]          phy_data_rx_phy2link,
  input  logic [NUM_LANES-1:0]       phy_bit_slip,
  input  logic [NUM_LANES-1:0]       phy_lane_polarity,
  output logic                       phy_tx_ready,
  output logic                       phy_rx_ready,
  output logic [DWIDTH-1:0]          bfm_tx_data,
  output logic                       bfm_tx_valid,
  input  logic [DWIDTH-1:0]          bfm_rx_data,
  input  logic [NUM_LANES-1:0]       cfg_lane_invert,
  input  logic                       cfg_offset_load,
  input  logic [NUM_LANES*OFF_W-1:0] cfg_lane_offset,
  output logic [NUM_LANES-1:0]       lane_aligned
);

  localparam int LANE_W = DWIDTH / NUM_LANES;
  localparam int CNT_W  = $clog2(max_int(TX_READY_DLY, RX_READY_DLY) + 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_READY_DLY - 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_READY_DLY - 1);

  phy_state_t        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              tx_ready_r;
  logic              rx_ready_r;
  logic [DWIDTH-1:0] tx_data_r;
  logic              tx_valid_r;
  logic [DWIDTH-1:0] rx_data_s;

  // Ready sequencing; dropping phy_init_cont_set returns to OFF from any state.
  always_ff @(posedge clk_hmc) begin
    if (!res_n_hmc) begin
      state_r    <= OFF;
      cnt_r      <= '0;
      tx_ready_r <= 1'b0;
      rx_ready_r <= 1'b0;
    end else if (!phy_init_cont_set) begin
      state_r    <= OFF;
      cnt_r      <= '0;
      tx_ready_r <= 1'b0;
      rx_ready_r <= 1'b0;
    end else begin
      case (state_r)
        OFF: begin
          state_r <= TX_WAIT;
          cnt_r   <= '0;
        end
        TX_WAIT: begin
          if (cnt_r == TX_LAST) begin
            state_r    <= RX_WAIT;
            cnt_r      <= '0;
            tx_ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RX_WAIT: begin
          if (cnt_r == RX_LAST) begin
            state_r    <= READY;
            cnt_r      <= '0;
            rx_ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        READY: begin
          tx_ready_r <= 1'b1;
          rx_ready_r <= 1'b1;
        end
        default: begin
          state_r    <= OFF;
          cnt_r      <= '0;
          tx_ready_r <= 1'b0;
          rx_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // TX pass-through, blanked until the transmitter is ready.
  always_ff @(posedge clk_hmc) begin
    if (!res_n_hmc) begin
      tx_data_r  <= '0;
      tx_valid_r <= 1'b0;
    end else begin
      tx_data_r  <= tx_ready_r ? phy_data_tx_link2phy : '0;
      tx_valid_r <= tx_ready_r;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] lane_in_s;
    logic [LANE_W-1:0] lane_out_s;

    for (genvar b = 0; b < LANE_W; b++) begin : g_bit
      assign lane_in_s[b] = bfm_rx_data[lane_bit_idx(l, b, NUM_LANES)];
      assign rx_data_s[lane_bit_idx(l, b, NUM_LANES)] = lane_out_s[b];
    end

    hmc_phy_lane_aligner #(
      .LANE_W (LANE_W),
      .OFF_W  (OFF_W)
    ) u_aligner (
      .clk         (clk_hmc),
      .res_n       (res_n_hmc),
      .rx_ready    (rx_ready_r),
      .slip        (phy_bit_slip[l]),
      .offset_load (cfg_offset_load),
      .offset_cfg  (cfg_lane_offset[l*OFF_W +: OFF_W]),
      .invert      (cfg_lane_invert[l]),
      .polarity    (phy_lane_polarity[l]),
      .lane_in     (lane_in_s),
      .lane_out    (lane_out_s),
      .aligned     (lane_aligned[l])
    );
  end

  // Gated by the registered ready so RX data is zero exactly while RX is not ready.
  assign phy_data_rx_phy2link = rx_data_s & {DWIDTH{rx_ready_r}};
  assign phy_tx_ready         = tx_ready_r;
  assign phy_rx_ready         = rx_ready_r;
  assign bfm_tx_data          = tx_data_r;
  assign bfm_tx_valid         = tx_valid_r;

endmodule

// File: tb/tb_hmc_phy_lane_model.sv
// Directed bench for hmc_phy_lane_model at DWIDTH=64, NUM_LANES=4, TX=4, RX=6.
module tb_hmc_phy_lane_model;

  localparam int DW = 64;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          init_set = 1'b0;
  logic [DW-1:0] tx_in = '0;
  logic [DW-1:0] rx_out;
  logic [NL-1:0] bit_slip = '0;
  logic [NL-1:0] polarity = '0;
  logic          tx_ready;
  logic          rx_ready;
  logic [DW-1:0] bfm_tx;
  logic          bfm_valid;
  logic [DW-1:0] bfm_rx = '0;
  logic [NL-1:0] lane_inv = '0;
  logic          off_load = 1'b0;
  logic [15:0]   lane_off = '0;
  logic [NL-1:0] aligned;

  int chk_cnt = 0;
  int err_cnt = 0;

  localparam logic [63:0] TX_WORD = 64'hDEAD_BEEF_0123_4567;

  always #5 clk = ~clk;

  hmc_phy_lane_model #(
    .DWIDTH       (DW),
    .NUM_LANES    (NL),
    .TX_READY_DLY (4),
    .RX_READY_DLY (6)
  ) dut (
    .clk_hmc              (clk),
    .res_n_hmc            (res_n),
    .phy_init_cont_set    (init_set),
    .phy_data_tx_link2phy (tx_in),
    .phy_data_rx_phy2link (rx_out),
    .phy_bit_slip         (bit_slip),
    .phy_lane_polarity    (polarity),
    .phy_tx_ready         (tx_ready),
    .phy_rx_ready         (rx_ready),
    .bfm_tx_data          (bfm_tx),
    .bfm_tx_valid         (bfm_valid),
    .bfm_rx_data          (bfm_rx),
    .cfg_lane_invert      (lane_inv),
    .cfg_offset_load      (off_load),
    .cfg_lane_offset      (lane_off),
    .lane_aligned         (aligned)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Interleave four lane words: lane l bit b at index b*4+l.
  function automatic logic [63:0] pack_lanes(input logic [15:0] l0, input logic [15:0] l1,
                                             input logic [15:0] l2, input logic [15:0] l3);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 16; b++) begin
      w[b*4+0] = l0[b];
      w[b*4+1] = l1[b];
      w[b*4+2] = l2[b];
      w[b*4+3] = l3[b];
    end
    return w;
  endfunction

  // Expects init_set already high; the next edge is cycle 0 of the ready sequence.
  task automatic run_ready_seq(input string tag);
    tick(4);
    check_val({tag, "_tx_rdy_c3"}, 64'(tx_ready), 64'd0);
    check_val({tag, "_txdata_c3"}, bfm_tx, 64'd0);
    tick(1);
    check_val({tag, "_tx_rdy_c4"}, 64'(tx_ready), 64'd1);
    check_val({tag, "_valid_c4"}, 64'(bfm_valid), 64'd0);
    tick(1);
    check_val({tag, "_valid_c5"}, 64'(bfm_valid), 64'd1);
    check_val({tag, "_txdata_c5"}, bfm_tx, TX_WORD);
    tick(4);
    check_val({tag, "_rx_rdy_c9"}, 64'(rx_ready), 64'd0);
    check_val({tag, "_rxdata_c9"}, rx_out, 64'd0);
    tick(1);
    check_val({tag, "_rx_rdy_c10"}, 64'(rx_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] base_w;
    base_w = pack_lanes(16'hF00F, 16'h0001, 16'h00FF, 16'h1234);

    // Reset state
    tick(3);
    check_val("rst_tx_ready", 64'(tx_ready), 64'd0);
    check_val("rst_rx_ready", 64'(rx_ready), 64'd0);
    check_val("rst_valid", 64'(bfm_valid), 64'd0);
    check_val("rst_txdata", bfm_tx, 64'd0);
    check_val("rst_rxdata", rx_out, 64'd0);
    check_val("rst_aligned", 64'(aligned), 64'hF);

    // 1: power-up sequence
    tx_in    = TX_WORD;
    bfm_rx   = 64'hAAAA_5555_0F0F_F0F0;
    res_n    = 1'b1;
    init_set = 1'b1;
    run_ready_seq("seq1");
    check_val("seq1_rxdata", rx_out, 64'hAAAA_5555_0F0F_F0F0);

    // 2: drop during RX_WAIT, then full restart
    init_set = 1'b0;
    tick(1);
    init_set = 1'b1;
    tick(7);
    check_val("drop_pre_tx", 64'(tx_ready), 64'd1);
    check_val("drop_pre_rx", 64'(rx_ready), 64'd0);
    init_set = 1'b0;
    tick(1);
    check_val("drop_tx", 64'(tx_ready), 64'd0);
    check_val("drop_rx", 64'(rx_ready), 64'd0);
    init_set = 1'b1;
    run_ready_seq("seq2");

    // 3: polarity impairment and correction
    lane_inv = 4'b0101;
    tick(2);
    check_val("invert", rx_out, 64'hFFFF_0000_5A5A_A5A5);
    polarity = 4'b0101;
    tick(2);
    check_val("pol_fix", rx_out, 64'hAAAA_5555_0F0F_F0F0);
    lane_inv = 4'b0000;
    polarity = 4'b0000;

    // 4: misalign lane1 by 3, then slip it back around
    bfm_rx   = base_w;
    lane_off = 16'h0030;
    off_load = 1'b1;
    tick(1);
    off_load = 1'b0;
    check_val("off3_aligned", 64'(aligned), 64'hD);
    tick(2);
    check_val("off3_data", rx_out, pack_lanes(16'hF00F, 16'h0008, 16'h00FF, 16'h1234));
    bit_slip = 4'b0010;
    tick(12);
    check_val("slip12_aligned", 64'(aligned), 64'hD);
    tick(1);
    bit_slip = 4'b0000;
    check_val("slip13_aligned", 64'(aligned), 64'hF);
    tick(1);
    check_val("slip13_data", rx_out, base_w);

    // 5: load beats same-cycle slip; slips ignored while RX not ready
    lane_off = 16'h0050;
    off_load = 1'b1;
    bit_slip = 4'b0010;
    tick(1);
    off_load = 1'b0;
    bit_slip = 4'b0000;
    check_val("ld_slip_aligned", 64'(aligned), 64'hD);
    tick(2);
    check_val("ld_slip_data", rx_out, pack_lanes(16'hF00F, 16'h0020, 16'h00FF, 16'h1234));
    init_set = 1'b0;
    tick(1);
    bit_slip = 4'b0010;
    tick(3);
    bit_slip = 4'b0000;
    init_set = 1'b1;
    run_ready_seq("seq5");
    check_val("noslip_data", rx_out, pack_lanes(16'hF00F, 16'h0020, 16'h00FF, 16'h1234));

    // 6: reset mid-stream with offsets loaded
    lane_off = 16'h1234;
    off_load = 1'b1;
    tick(1);
    off_load = 1'b0;
    check_val("off_all_aligned", 64'(aligned), 64'h0);
    tick(2);
    res_n = 1'b0;
    tick(1);
    check_val("mid_rst_tx_ready", 64'(tx_ready), 64'd0);
    check_val("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    check_val("mid_rst_valid", 64'(bfm_valid), 64'd0);
    check_val("mid_rst_txdata", bfm_tx, 64'd0);
    check_val("mid_rst_rxdata", rx_out, 64'd0);
    check_val("mid_rst_aligned", 64'(aligned), 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
